// File: rtl/seg_disp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared constants and types for the 6-digit hex display
//           controller: display geometry, blank value, FSM state encoding
//           and the arbitration result record.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam int SEG_DIGITS   = 6;
  localparam int SEG_NIBBLE_W = 4;
  localparam int SEG_DATA_W   = SEG_DIGITS * SEG_NIBBLE_W;  // 24
  localparam int SEG_OWNER_W  = 3;                          // up to 8 requesters

  localparam logic [SEG_DATA_W-1:0] SEG_BLANK = 24'h000000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seg_state_e;

  // Outcome of one round-robin search.
  typedef struct packed {
    logic                   found;
    logic [SEG_OWNER_W-1:0] idx;
  } seg_pick_t;

endpackage
`default_nettype wire

// File: rtl/seg_disp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_disp_ctrl_if
// Purpose : Request/display bundle between the requesters and the display
//           controller.
// Signals : i_req       per-requester level request
//           i_data      requester k value at [24k+23:24k]
//           o_ack       one-cycle grant pulse
//           o_disp_data latched display value
//           o_owner     index of last granted requester
//           o_busy      high while a value is being held
// Modports: master = requester side, slave = controller side
// Rev     : 1.0  initial release
// ============================================================================
interface seg_disp_ctrl_if
  import seg_pkg::*;
#(
  parameter int N_REQ = 3
);

  logic [N_REQ-1:0]            i_req;
  logic [SEG_DATA_W*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]            o_ack;
  logic [SEG_DATA_W-1:0]       o_disp_data;
  logic [SEG_OWNER_W-1:0]      o_owner;
  logic                        o_busy;

  modport master (
    output i_req, i_data,
    input  o_ack, o_disp_data, o_owner, o_busy
  );

  modport slave (
    input  i_req, i_data,
    output o_ack, o_disp_data, o_owner, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/seg_disp_ctrl_scan_div.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_div
// Purpose : Free-running divider producing the 50% duty digit-scan clock.
//           o_scan_clk toggles every SCAN_DIV input cycles (period
//           2*SCAN_DIV).
// Ports   : i_clk      system clock
//           i_rst_n    asynchronous active-low reset
//           o_scan_clk divided scan clock (registered)
// Rev     : 1.0  initial release
// ============================================================================
module seg_scan_div #(
  parameter int SCAN_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_scan_clk
);

  localparam int            SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] cnt_q;
  logic              scan_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      scan_q <= 1'b0;
    end else if (cnt_q == SCAN_LAST) begin
      cnt_q  <= '0;
      scan_q <= ~scan_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign o_scan_clk = scan_q;

endmodule
`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_disp_ctrl
// Purpose : Shares a 6-digit hex display between N_REQ requesters. Grants
//           round-robin, snapshots the winner's 24-bit value, holds it for
//           HOLD_CYC cycles, then re-arbitrates. Also generates the
//           digit-scan clock.
// Ports   : i_clk      system clock
//           i_rst_n    asynchronous active-low reset
//           bus        seg_disp_ctrl_if.slave (req/data in, ack/disp/owner/
//                      busy out, all outputs registered)
//           o_scan_clk 50% duty scan clock, half-period SCAN_DIV cycles
// Rev     : 1.0  initial release
// ============================================================================
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int HOLD_CYC = 50000000,
  parameter int SCAN_DIV = 250
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  seg_disp_ctrl_if.slave  bus,
  output logic            o_scan_clk
);

  localparam int               CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

  // First requester with req set, searching upward from ptr+1 with wrap.
  // The current pointer is visited last, so a lone requester can win again.
  function automatic seg_pick_t rr_pick(input logic [SEG_OWNER_W-1:0] ptr,
                                        input logic [N_REQ-1:0]       req);
    seg_pick_t        pick;
    logic [N_REQ-1:0] sh;
    int               idx;
    pick.found = 1'b0;
    pick.idx   = ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      sh  = req >> idx;
      if (!pick.found && sh[0]) begin
        pick.found = 1'b1;
        pick.idx   = SEG_OWNER_W'(idx);
      end
    end
    return pick;
  endfunction

  seg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEG_OWNER_W-1:0] ptr_q, ptr_d;
  logic [SEG_DATA_W-1:0]  disp_q, disp_d;
  logic [SEG_OWNER_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   busy_q, busy_d;
  seg_pick_t              pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    disp_d  = disp_q;
    owner_d = owner_q;
    ack_d   = '0;
    busy_d  = busy_q;
    pick    = rr_pick(ptr_q, bus.i_req);

    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d = ST_HOLD;
          disp_d  = SEG_DATA_W'(bus.i_data >> (int'(pick.idx) * SEG_DATA_W));
          for (int k = 0; k < N_REQ; k++) begin
            ack_d[k] = (k == int'(pick.idx));
          end
          owner_d = pick.idx;
          ptr_d   = pick.idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // Requests are ignored here: the dwell always runs to completion.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      disp_q  <= SEG_BLANK;
      owner_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      disp_q  <= disp_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_ack       = ack_q;
  assign bus.o_disp_data = disp_q;
  assign bus.o_owner     = owner_q;
  assign bus.o_busy      = busy_q;

  seg_scan_div #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_scan_clk (o_scan_clk)
  );

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_disp_ctrl
// Purpose : Self-checking bench for seg_disp_ctrl (N_REQ=3, HOLD_CYC=4,
//           SCAN_DIV=2). A behavioural model tracks dwell time, the
//           round-robin pointer and the scan clock phase; directed sequences
//           pin the model with literal expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seg_disp_ctrl;
  import seg_pkg::*;

  localparam int N  = 3;
  localparam int HC = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan;

  seg_disp_ctrl_if #(.N_REQ(N)) bus ();

  seg_disp_ctrl #(
    .N_REQ    (N),
    .HOLD_CYC (HC),
    .SCAN_DIV (SD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_scan_clk (scan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr, m_left, m_owner, m_edges, m_w;
  logic [23:0] m_disp;
  logic [N-1:0] m_ack;
  bit          m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_left = 0; m_owner = 0; m_edges = 0;
      m_disp = 24'h0; m_ack = '0; m_busy = 0;
    end else begin
      m_edges++;
      m_ack = '0;
      if (m_left > 0) begin
        m_left--;
        m_busy = (m_left > 0);
      end else begin
        m_w = -1;
        for (int i = 1; i <= N; i++) begin
          if (m_w < 0 && bus.i_req[(m_ptr + i) % N]) m_w = (m_ptr + i) % N;
        end
        if (m_w >= 0) begin
          m_ack[m_w] = 1'b1;
          m_disp     = bus.i_data[m_w*24 +: 24];
          m_owner    = m_w;
          m_ptr      = m_w;
          m_left     = HC;
          m_busy     = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack",   32'(bus.o_ack),       32'(m_ack));
      chk("disp",  32'(bus.o_disp_data), 32'(m_disp));
      chk("owner", 32'(bus.o_owner),     32'(m_owner));
      chk("busy",  32'(bus.o_busy),      32'(m_busy));
      chk("scan",  32'(scan),            32'((m_edges / SD) % 2));
    end
  end

  // Grant log used by the directed ordering checks.
  int          cyc = 0;
  int          log_idx[$];
  int          log_cyc[$];
  logic [23:0] log_disp[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n && bus.o_ack != '0) begin
      for (int k = 0; k < N; k++) begin
        if (bus.o_ack[k]) log_idx.push_back(k);
      end
      log_cyc.push_back(cyc);
      log_disp.push_back(bus.o_disp_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0;
    step(2);
    rst_n = 1'b1;
    log_idx.delete();
    log_cyc.delete();
    log_disp.delete();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.o_busy && k < 20) begin
      step(1);
      k++;
    end
    if (bus.o_busy) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  int   tog, bc, k2;
  logic prev;
  bit   saw2;

  initial begin
    bus.i_req  = '0;
    bus.i_data = '0;

    // 1: reset values and idle scan clock
    do_reset();
    chk("rst_disp",  32'(bus.o_disp_data), 32'h0);
    chk("rst_ack",   32'(bus.o_ack),       32'h0);
    chk("rst_busy",  32'(bus.o_busy),      32'h0);
    chk("rst_owner", 32'(bus.o_owner),     32'h0);
    chk("rst_scan",  32'(scan),            32'h0);
    tog  = 0;
    prev = scan;
    repeat (20) begin
      @(negedge clk);
      if (scan !== prev) tog++;
      prev = scan;
    end
    #1;
    chk("idle_scan_toggles", 32'(tog), 32'd10);
    chk("idle_disp", 32'(bus.o_disp_data), 32'h0);
    chk("idle_busy", 32'(bus.o_busy), 32'h0);

    // 2: single request from requester 1
    bus.i_data = {24'h000000, 24'h123456, 24'h000000};
    bus.i_req  = 3'b010;
    step(1);
    chk("single_ack",   32'(bus.o_ack),       32'h2);
    chk("single_disp",  32'(bus.o_disp_data), 32'h123456);
    chk("single_owner", 32'(bus.o_owner),     32'h1);
    bus.i_req = '0;
    bc = bus.o_busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (bus.o_busy) bc++;
      else break;
    end
    chk("single_busy_cycles", 32'(bc), 32'd4);
    chk("single_ack_done", 32'(bus.o_ack), 32'h0);

    // 3: all three held high -> grant order 1,2,0,1 spaced HC+1
    do_reset();
    bus.i_data = {24'h333333, 24'h222222, 24'h111111};
    bus.i_req  = 3'b111;
    k2 = 0;
    while (log_idx.size() < 4 && k2 < 40) begin
      step(1);
      k2++;
    end
    bus.i_req = '0;
    if (log_idx.size() < 4) begin
      chk("rr_grant_timeout", 32'(log_idx.size()), 32'd4);
    end else begin
      chk("rr_g0", 32'(log_idx[0]), 32'd1);
      chk("rr_g1", 32'(log_idx[1]), 32'd2);
      chk("rr_g2", 32'(log_idx[2]), 32'd0);
      chk("rr_g3", 32'(log_idx[3]), 32'd1);
      chk("rr_gap0", 32'(log_cyc[1] - log_cyc[0]), 32'(HC + 1));
      chk("rr_gap1", 32'(log_cyc[2] - log_cyc[1]), 32'(HC + 1));
      chk("rr_gap2", 32'(log_cyc[3] - log_cyc[2]), 32'(HC + 1));
      chk("rr_d0", 32'(log_disp[0]), 32'h222222);
      chk("rr_d1", 32'(log_disp[1]), 32'h333333);
      chk("rr_d2", 32'(log_disp[2]), 32'h111111);
      chk("rr_d3", 32'(log_disp[3]), 32'h222222);
    end
    wait_idle("rr");

    // 4: snapshot during HOLD, no pre-emption, transient req2 ignored
    do_reset();
    bus.i_data = {24'h333333, 24'h123456, 24'h111111};
    bus.i_req  = 3'b010;
    step(1);
    chk("snap_owner", 32'(bus.o_owner), 32'h1);
    bus.i_data[47:24] = 24'hABCDEF;
    bus.i_req = 3'b101;
    step(1);
    bus.i_req = 3'b001;
    k2 = 0;
    while (bus.o_busy && k2 < 20) begin
      chk("snap_hold_disp", 32'(bus.o_disp_data), 32'h123456);
      step(1);
      k2++;
    end
    k2 = 0;
    while (bus.o_ack == '0 && k2 < 10) begin
      step(1);
      k2++;
    end
    chk("snap_next_ack",   32'(bus.o_ack),       32'h1);
    chk("snap_next_owner", 32'(bus.o_owner),     32'h0);
    chk("snap_next_disp",  32'(bus.o_disp_data), 32'h111111);
    bus.i_req = '0;
    wait_idle("snap");
    saw2 = 0;
    foreach (log_idx[i]) if (log_idx[i] == 2) saw2 = 1;
    chk("pulse_req2_never_acked", 32'(saw2), 32'd0);

    // 5: asynchronous reset two cycles into HOLD
    do_reset();
    bus.i_data = {24'h333333, 24'h222222, 24'h111111};
    bus.i_req  = 3'b010;
    step(1);
    bus.i_req = '0;
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst_disp",  32'(bus.o_disp_data), 32'h0);
    chk("arst_busy",  32'(bus.o_busy),      32'h0);
    chk("arst_ack",   32'(bus.o_ack),       32'h0);
    chk("arst_scan",  32'(scan),            32'h0);
    chk("arst_owner", 32'(bus.o_owner),     32'h0);
    step(1);
    rst_n = 1'b1;
    bus.i_req = 3'b111;
    step(1);
    chk("arst_first_ack",   32'(bus.o_ack),   32'h2);
    chk("arst_first_owner", 32'(bus.o_owner), 32'h1);
    bus.i_req = '0;
    wait_idle("arst");

    // 6: randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.i_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        bus.i_data[24*$urandom_range(0, N-1) +: 24] = 24'($urandom);
      step(1);
    end
    bus.i_req = '0;
    step(HC + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
